// File: rtl/wshb_pixel_sink.sv
// wshb_pixel_sink: Wishbone classic-cycle responder for a pixel-write stream.
// Stores DATA_W-bit pixels in byte-lane RAMs and serves read-back.
// It counts accepted pixel writes and pulses frame_done at the end of each frame.
// Every access takes two cycles: the IDLE edge decodes, commits and updates the counters.
// The RESP cycle then presents ack or err.
module wshb_pixel_sink #(
  parameter int DATA_W      = 16,
  parameter int ADR_W       = 32,
  parameter int DEPTH       = 4096,
  parameter int FRAME_WORDS = 307200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic [ADR_W-1:0]      adr,
  input  logic [DATA_W/8-1:0]   sel,
  input  logic [DATA_W-1:0]     dat_ms,
  output logic [DATA_W-1:0]     dat_sm,
  output logic                  ack,
  output logic                  err,
  output logic                  frame_done,
  output logic [((FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1)-1:0] wr_count
);

  localparam int CNT_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANES  = DATA_W / 8;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RESP = 1'b1;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_WORDS - 1);

  logic              state_reg;
  logic              ack_reg;
  logic              err_reg;
  logic              frame_done_reg;
  logic              frame_done_next;
  logic [CNT_W-1:0]  wr_count_reg;
  logic [CNT_W-1:0]  wr_count_next;

  logic [ADR_W-2:0]  idx;
  logic [RAM_AW-1:0] ram_adr;
  logic              req;
  logic              in_range;
  logic              ram_wr;
  logic              ram_rd;
  logic              pixel_wr;
  logic              unused_adr_lsb;

  // adr[0] selects a byte inside a 16-bit word and has no meaning for this slave.
  assign unused_adr_lsb = adr[0];

  assign idx      = adr[ADR_W-1:1];
  assign in_range = ({1'b0, idx} < ADR_W'(DEPTH));
  assign ram_adr  = idx[RAM_AW-1:0];

  // New requests are only sampled in IDLE, so each access costs exactly two cycles.
  assign req      = (state_reg == STATE_IDLE) && cyc && stb;
  assign ram_wr   = req && in_range && we;
  assign ram_rd   = req && in_range && !we;
  assign pixel_wr = ram_wr && (|sel);

  // Frame counter: writing word 0 resyncs the frame, and the last pixel wraps the count and flags frame end.
  always_comb begin
    wr_count_next   = wr_count_reg;
    frame_done_next = 1'b0;
    if (pixel_wr) begin
      if (idx == '0) begin
        if (FRAME_WORDS == 1) begin
          wr_count_next   = '0;
          frame_done_next = 1'b1;
        end else begin
          wr_count_next = CNT_W'(1);
        end
      end else if (wr_count_reg == LAST_COUNT) begin
        wr_count_next   = '0;
        frame_done_next = 1'b1;
      end else begin
        wr_count_next = wr_count_reg + 1'b1;
      end
    end
  end

  // Two-state handshake FSM and the registered termination and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= STATE_IDLE;
      ack_reg        <= 1'b0;
      err_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
      wr_count_reg   <= '0;
    end else begin
      state_reg      <= req ? STATE_RESP : STATE_IDLE;
      ack_reg        <= req && in_range;
      err_reg        <= req && !in_range;
      frame_done_reg <= frame_done_next;
      wr_count_reg   <= wr_count_next;
    end
  end

  // One RAM per byte lane, so each sel bit gates its own lane.
  // Each lane has its own registered read.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_lane_reg;

      // Byte-lane write port, committed at the IDLE edge of an in-range write.
      always_ff @(posedge clk) begin
        if (ram_wr && sel[gi]) begin
          mem[ram_adr] <= dat_ms[gi*8 +: 8];
        end
      end

      // Registered read data, held between reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_lane_reg <= '0;
        end else if (ram_rd) begin
          rd_lane_reg <= mem[ram_adr];
        end
      end

      assign dat_sm[gi*8 +: 8] = rd_lane_reg;
    end
  endgenerate

  // A master dropping cyc during RESP silently aborts the termination.
  assign ack        = ack_reg & cyc;
  assign err        = err_reg & cyc;
  assign frame_done = frame_done_reg;
  assign wr_count   = wr_count_reg;

endmodule

// File: tb/tb_wshb_pixel_sink.sv
// tb_wshb_pixel_sink: directed self-checking bench for wshb_pixel_sink with FRAME_WORDS=16.
module tb_wshb_pixel_sink;

  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [1:0]  sel;
  logic [15:0] dat_ms;
  logic [15:0] dat_sm;
  logic        ack;
  logic        err;
  logic        frame_done;
  logic [3:0]  wr_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Results of the most recent xfer.
  logic        o_pre;
  logic        o_ack;
  logic        o_err;
  logic        o_fd;
  logic [15:0] o_dat;
  logic [3:0]  o_cnt;
  logic        o_post;

  wshb_pixel_sink #(
    .DATA_W(16), .ADR_W(32), .DEPTH(DEPTH), .FRAME_WORDS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
    .sel(sel), .dat_ms(dat_ms), .dat_sm(dat_sm), .ack(ack), .err(err),
    .frame_done(frame_done), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One request: drive at negedge, sample in RESP, sample again after returning to IDLE.
  // cyc/stb stay high afterwards, so consecutive calls run back to back.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [15:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_ms = d;
    o_pre = ack | err;
    @(posedge clk); #1;
    o_ack = ack; o_err = err; o_fd = frame_done; o_dat = dat_sm; o_cnt = wr_count;
    @(posedge clk); #1;
    o_post = ack | err | frame_done;
    $display("xfer we=%0b adr=%08h sel=%02b dat_ms=%04h -> ack=%0b err=%0b fd=%0b dat_sm=%04h wr_count=%0d",
             w, a, s, d, o_ack, o_err, o_fd, o_dat, o_cnt);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_ms = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (ack !== 1'b0) $display("FAIL rst_ack got=%0b exp=0", ack); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rst_err got=%0b exp=0", err); else pass_cnt++;
    total_cnt++; if (dat_sm !== 16'h0000) $display("FAIL rst_dat got=%04h exp=0000", dat_sm); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL rst_fd got=%0b exp=0", frame_done); else pass_cnt++;
    total_cnt++; if (wr_count !== 4'd0) $display("FAIL rst_cnt got=%0d exp=0", wr_count); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    xfer(1'b1, 32'd10, 2'b11, 16'hA5C3);
    total_cnt++; if (o_pre !== 1'b0) $display("FAIL t1_wr_early got=%0b exp=0", o_pre); else pass_cnt++;
    total_cnt++; if (o_ack !== 1'b1) $display("FAIL t1_wr_ack got=%0b exp=1", o_ack); else pass_cnt++;
    total_cnt++; if (o_err !== 1'b0) $display("FAIL t1_wr_err got=%0b exp=0", o_err); else pass_cnt++;
    total_cnt++; if (o_post !== 1'b0) $display("FAIL t1_wr_one_cycle got=%0b exp=0", o_post); else pass_cnt++;
    total_cnt++; if (o_cnt !== 4'd1) $display("FAIL t1_wr_cnt got=%0d exp=1", o_cnt); else pass_cnt++;
    bus_idle();
    // adr[0] set on the read: it must address the same word.
    xfer(1'b0, 32'd11, 2'b11, 16'h0000);
    total_cnt++; if (o_ack !== 1'b1) $display("FAIL t1_rd_ack got=%0b exp=1", o_ack); else pass_cnt++;
    total_cnt++; if (o_err !== 1'b0) $display("FAIL t1_rd_err got=%0b exp=0", o_err); else pass_cnt++;
    total_cnt++; if (o_dat !== 16'hA5C3) $display("FAIL t1_rd_dat got=%04h exp=A5C3", o_dat); else pass_cnt++;
    total_cnt++; if (o_cnt !== 4'd1) $display("FAIL t1_rd_cnt got=%0d exp=1", o_cnt); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_byte_enables();
    xfer(1'b1, 32'd14, 2'b11, 16'hFFFF);
    xfer(1'b1, 32'd14, 2'b10, 16'h1200);
    total_cnt++; if (o_cnt !== 4'd3) $display("FAIL t2_cnt got=%0d exp=3", o_cnt); else pass_cnt++;
    xfer(1'b0, 32'd14, 2'b11, 16'h0000);
    total_cnt++; if (o_dat !== 16'h12FF) $display("FAIL t2_merge got=%04h exp=12FF", o_dat); else pass_cnt++;
    // A write with no byte enables is acked but changes nothing.
    xfer(1'b1, 32'd14, 2'b00, 16'h3456);
    total_cnt++; if (o_ack !== 1'b1) $display("FAIL t2_sel0_ack got=%0b exp=1", o_ack); else pass_cnt++;
    total_cnt++; if (o_cnt !== 4'd3) $display("FAIL t2_sel0_cnt got=%0d exp=3", o_cnt); else pass_cnt++;
    xfer(1'b0, 32'd14, 2'b11, 16'h0000);
    total_cnt++; if (o_dat !== 16'h12FF) $display("FAIL t2_sel0_dat got=%04h exp=12FF", o_dat); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_out_of_range();
    xfer(1'b1, 32'd0, 2'b11, 16'h1111);
    total_cnt++; if (o_cnt !== 4'd1) $display("FAIL t3_idx0_cnt got=%0d exp=1", o_cnt); else pass_cnt++;
    xfer(1'b1, 32'(2 * DEPTH), 2'b11, 16'hDEAD);
    total_cnt++; if (o_err !== 1'b1) $display("FAIL t3_wr_err got=%0b exp=1", o_err); else pass_cnt++;
    total_cnt++; if (o_ack !== 1'b0) $display("FAIL t3_wr_ack got=%0b exp=0", o_ack); else pass_cnt++;
    total_cnt++; if (o_post !== 1'b0) $display("FAIL t3_wr_err_len got=%0b exp=0", o_post); else pass_cnt++;
    total_cnt++; if (o_cnt !== 4'd1) $display("FAIL t3_wr_cnt got=%0d exp=1", o_cnt); else pass_cnt++;
    xfer(1'b0, 32'(2 * DEPTH), 2'b11, 16'h0000);
    total_cnt++; if (o_err !== 1'b1) $display("FAIL t3_rd_err got=%0b exp=1", o_err); else pass_cnt++;
    total_cnt++; if (o_ack !== 1'b0) $display("FAIL t3_rd_ack got=%0b exp=0", o_ack); else pass_cnt++;
    total_cnt++; if (o_dat !== 16'h12FF) $display("FAIL t3_rd_hold got=%04h exp=12FF", o_dat); else pass_cnt++;
    xfer(1'b0, 32'd0, 2'b11, 16'h0000);
    total_cnt++; if (o_dat !== 16'h1111) $display("FAIL t3_ram_intact got=%04h exp=1111", o_dat); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 32'(2 * i), 2'b11, 16'h0100 + 16'(i));
      total_cnt++; if (o_pre !== 1'b0) $display("FAIL t4_gap_%0d got=%0b exp=0", i, o_pre); else pass_cnt++;
      total_cnt++; if (o_ack !== 1'b1) $display("FAIL t4_ack_%0d got=%0b exp=1", i, o_ack); else pass_cnt++;
      if (i < 15) begin
        total_cnt++; if (o_fd !== 1'b0) $display("FAIL t4_fd_early_%0d got=%0b exp=0", i, o_fd); else pass_cnt++;
        total_cnt++; if (o_cnt !== 4'(i + 1)) $display("FAIL t4_cnt_%0d got=%0d exp=%0d", i, o_cnt, i + 1); else pass_cnt++;
      end else begin
        total_cnt++; if (o_fd !== 1'b1) $display("FAIL t4_fd_last got=%0b exp=1", o_fd); else pass_cnt++;
        total_cnt++; if (o_cnt !== 4'd0) $display("FAIL t4_cnt_wrap got=%0d exp=0", o_cnt); else pass_cnt++;
        total_cnt++; if (o_post !== 1'b0) $display("FAIL t4_fd_len got=%0b exp=0", o_post); else pass_cnt++;
      end
    end
    xfer(1'b1, 32'd0, 2'b11, 16'h0200);
    total_cnt++; if (o_cnt !== 4'd1) $display("FAIL t4_resync got=%0d exp=1", o_cnt); else pass_cnt++;
    total_cnt++; if (o_fd !== 1'b0) $display("FAIL t4_fd_17 got=%0b exp=0", o_fd); else pass_cnt++;
    xfer(1'b0, 32'd6, 2'b11, 16'h0000);
    total_cnt++; if (o_dat !== 16'h0103) $display("FAIL t4_rd3 got=%04h exp=0103", o_dat); else pass_cnt++;
    xfer(1'b0, 32'd30, 2'b11, 16'h0000);
    total_cnt++; if (o_dat !== 16'h010F) $display("FAIL t4_rd15 got=%04h exp=010F", o_dat); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_abort();
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd40; sel = 2'b11; dat_ms = 16'h5A5A;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1;
    $display("abort write adr=%08h -> ack=%0b err=%0b wr_count=%0d", 32'd40, ack, err, wr_count);
    total_cnt++; if (ack !== 1'b0) $display("FAIL t5_ack_gated got=%0b exp=0", ack); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL t5_err_gated got=%0b exp=0", err); else pass_cnt++;
    total_cnt++; if (wr_count !== 4'd2) $display("FAIL t5_cnt got=%0d exp=2", wr_count); else pass_cnt++;
    @(posedge clk);
    xfer(1'b0, 32'd40, 2'b11, 16'h0000);
    total_cnt++; if (o_ack !== 1'b1) $display("FAIL t5_rd_ack got=%0b exp=1", o_ack); else pass_cnt++;
    total_cnt++; if (o_dat !== 16'h5A5A) $display("FAIL t5_rd_dat got=%04h exp=5A5A", o_dat); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd60; sel = 2'b11; dat_ms = 16'h7777;
    @(posedge clk); #1;
    total_cnt++; if (ack !== 1'b1) $display("FAIL t6_pre_ack got=%0b exp=1", ack); else pass_cnt++;
    total_cnt++; if (wr_count !== 4'd3) $display("FAIL t6_pre_cnt got=%0d exp=3", wr_count); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    $display("async reset in RESP -> ack=%0b err=%0b fd=%0b wr_count=%0d", ack, err, frame_done, wr_count);
    total_cnt++; if (ack !== 1'b0) $display("FAIL t6_rst_ack got=%0b exp=0", ack); else pass_cnt++;
    total_cnt++; if (wr_count !== 4'd0) $display("FAIL t6_rst_cnt got=%0d exp=0", wr_count); else pass_cnt++;
    total_cnt++; if (dat_sm !== 16'h0000) $display("FAIL t6_rst_dat got=%04h exp=0000", dat_sm); else pass_cnt++;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    xfer(1'b1, 32'd62, 2'b11, 16'h8888);
    total_cnt++; if (o_pre !== 1'b0) $display("FAIL t6_post_early got=%0b exp=0", o_pre); else pass_cnt++;
    total_cnt++; if (o_ack !== 1'b1) $display("FAIL t6_post_ack got=%0b exp=1", o_ack); else pass_cnt++;
    total_cnt++; if (o_cnt !== 4'd1) $display("FAIL t6_post_cnt got=%0d exp=1", o_cnt); else pass_cnt++;
    xfer(1'b0, 32'd60, 2'b11, 16'h0000);
    total_cnt++; if (o_dat !== 16'h7777) $display("FAIL t6_ram_kept got=%04h exp=7777", o_dat); else pass_cnt++;
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_out_of_range();
    test_back_to_back();
    test_abort();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
